// File: rtl/mix_columns_serial_pkg.sv
// rtl/mix_columns_serial_pkg.sv - AES MixColumns types and GF(2^8) helpers
package AESDefinitions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  typedef logic [1:0] col_idx_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the constants used by the forward and inverse matrices are supported.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   return x2;
      8'h03:   return x2 ^ b;
      8'h09:   return x8 ^ b;
      8'h0b:   return x8 ^ x2 ^ b;
      8'h0d:   return x8 ^ x4 ^ b;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational forward/inverse MixColumns on one 32-bit column
module mix_column_word
  import AESDefinitions::*;
(
  input  logic [31:0] in_word,
  input  logic        inverse,
  output logic [31:0] out_word
);

  logic [7:0] a [4];
  logic [7:0] r [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = in_word[31-8*i -: 8];
    end
    // Row i is the base row rotated right by i, so a[i+k] pairs with coefficient k.
    for (int i = 0; i < 4; i++) begin
      if (inverse) begin
        r[i] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b)
             ^ gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
      end else begin
        r[i] = gf_mul(a[i], 8'h02) ^ gf_mul(a[(i+1)%4], 8'h03)
             ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    out_word = {r[0], r[1], r[2], r[3]};
  end

endmodule

// File: rtl/mix_columns_serial.sv
// rtl/mix_columns_serial.sv - column-serial MixColumns/InvMixColumns stage with bypass
module mix_columns_serial
  import AESDefinitions::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  mix_state_e   state_q, state_d;
  col_idx_t     col_q, col_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;

  logic [6:0]  col_lsb;
  logic [31:0] col_in, col_out;
  logic        accept;

  // Column c sits at bit offset 32*(3-c); for a 2-bit c, 3-c is ~c.
  assign col_lsb = {~col_q, 5'b0};
  assign col_in  = work_q[col_lsb +: 32];

  mix_column_word u_mix_column_word (
    .in_word  (col_in),
    .inverse  (mode_q),
    .out_word (col_out)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    mode_d  = mode_q;
    unique case (state_q)
      BUSY: begin
        work_d[col_lsb +: 32] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      work_d  = in_data;
      mode_d  = in_inverse;
      col_d   = '0;
      state_d = in_bypass ? DONE : BUSY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_serial.sv
// tb/tb_mix_columns_serial.sv - directed self-checking bench for mix_columns_serial
module tb_mix_columns_serial;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inverse;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN   = 128'h01010101c6c6c6c6d4d4d4d52d26314c;
  localparam logic [127:0] COL_OUT  = 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8;
  localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

  mix_columns_serial dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inverse (in_inverse),
    .in_bypass  (in_bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Presents one state, waits for its acceptance edge, then reports how many
  // further edges passed before out_valid was seen (bounded).
  task automatic send(input logic [127:0] d, input logic inv, input logic byp,
                      output int edges);
    int n;
    @(negedge clock);
    in_valid   = 1'b1;
    in_data    = d;
    in_inverse = inv;
    in_bypass  = byp;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    @(negedge clock);
    in_valid  = 1'b0;
    in_data   = '0;
    in_bypass = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1; in_data = FIPS_IN; in_inverse = 1'b0; in_bypass = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_forward();
    int e;
    out_ready = 1'b1;
    send(FIPS_IN, 1'b0, 1'b0, e);
    n_checks++;
    if (e !== 4) begin
      n_fail++; $display("FAIL fwd_latency got=%0d exp=4", e);
    end
    n_checks++;
    if (out_data !== FIPS_OUT) begin
      n_fail++; $display("FAIL fwd_data got=%h exp=%h", out_data, FIPS_OUT);
    end
    drain();
  endtask

  task automatic test_inverse();
    int e;
    send(FIPS_OUT, 1'b1, 1'b0, e);
    n_checks++;
    if (e !== 4) begin
      n_fail++; $display("FAIL inv_latency got=%0d exp=4", e);
    end
    n_checks++;
    if (out_data !== FIPS_IN) begin
      n_fail++; $display("FAIL inv_data got=%h exp=%h", out_data, FIPS_IN);
    end
    drain();
  endtask

  task automatic test_columns();
    int e;
    send(COL_IN, 1'b0, 1'b0, e);
    n_checks++;
    if (out_data !== COL_OUT) begin
      n_fail++; $display("FAIL col_fwd_data got=%h exp=%h", out_data, COL_OUT);
    end
    drain();
    send(COL_OUT, 1'b1, 1'b0, e);
    n_checks++;
    if (out_data !== COL_IN) begin
      n_fail++; $display("FAIL col_inv_data got=%h exp=%h", out_data, COL_IN);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int e;
    out_ready = 1'b0;
    send(FIPS_IN, 1'b0, 1'b0, e);
    n_checks++;
    if (e !== 4) begin
      n_fail++; $display("FAIL bp_latency got=%0d exp=4", e);
    end
    in_valid = 1'b1; in_data = BYP_IN; in_inverse = 1'b0; in_bypass = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid);
      end
      n_checks++;
      if (out_data !== FIPS_OUT) begin
        n_fail++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, out_data, FIPS_OUT);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, in_ready);
      end
    end
    in_data = FIPS_OUT; in_inverse = 1'b1; in_bypass = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_consumed_valid got=%b exp=0", out_valid);
    end
    e = 0;
    while (!out_valid && e < 20) begin
      @(negedge clock);
      e++;
    end
    n_checks++;
    if (e !== 4) begin
      n_fail++; $display("FAIL b2b_latency got=%0d exp=4", e);
    end
    n_checks++;
    if (out_data !== FIPS_IN) begin
      n_fail++; $display("FAIL b2b_data got=%h exp=%h", out_data, FIPS_IN);
    end
    drain();
  endtask

  task automatic test_bypass();
    int e;
    send(BYP_IN, 1'b1, 1'b1, e);
    n_checks++;
    if (e !== 0) begin
      n_fail++; $display("FAIL byp_latency got=%0d exp=0", e);
    end
    n_checks++;
    if (out_data !== BYP_IN) begin
      n_fail++; $display("FAIL byp_data got=%h exp=%h", out_data, BYP_IN);
    end
    drain();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL byp_idle_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    @(negedge clock);
    in_valid = 1'b1; in_data = COL_IN; in_inverse = 1'b0; in_bypass = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++; $display("FAIL rst_mid_data got=%h exp=0", out_data);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_stale got=%b exp=0", out_valid);
    end
    send(FIPS_IN, 1'b0, 1'b0, e);
    n_checks++;
    if (e !== 4) begin
      n_fail++; $display("FAIL rst_after_latency got=%0d exp=4", e);
    end
    n_checks++;
    if (out_data !== FIPS_OUT) begin
      n_fail++; $display("FAIL rst_after_data got=%h exp=%h", out_data, FIPS_OUT);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_columns();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
